uart_tx_ctrl: RTL and testbench
===============================

# uart_tx_ctrl

UART transmit controller that sequences serial frames against the 16x oversampling tick from the baud generator and owns that generator's `set_baud` selection. It sits between the bus-side UART register logic and the `txd` pin. Each accepted byte is serialised as start, data (LSB first), optional parity and stop bits. Baud-rate changes are applied only between frames.

## Interface
- `DATA_BITS`, 8: data bits per frame, 5..8.
- `OVERSAMPLE`, 16: baudticks per bit period.
- `STOP_BITS`, 1: stop bits per frame, 1 or 2.
- `DEFAULT_BAUD`, 4'd8: `set_baud` reset value (8 = 19200 bit/s).
- `clk` in 1: system clock.
- `resetn` in 1: reset, asynchronous, active-low.
- `baudtick` in 1: one-cycle oversample tick from the baud generator.
- `tx_data` in DATA_BITS: byte to send.
- `tx_valid` in 1: `tx_data` valid.
- `tx_ready` out 1: controller accepts `tx_data` this cycle.
- `baud_wr` in 1: request a baud change.
- `baud_sel` in 4: requested rate index, 0..13; values above 13 are clamped to 13.
- `set_baud` out 4: rate index driven to the baud generator.
- `baud_pending` out 1: a baud change is latched but not yet applied.
- `txd` out 1: serial output, idle high.
- `tx_busy` out 1: high whenever the state is not IDLE or SETTLE.
- `parity_odd` in 1: 1 selects odd parity, 0 selects even. This port exists only with `UART_TX_PARITY_EN`.

## Operation
- States: IDLE, START, DATA, PARITY, STOP, SETTLE.
- Counters:
  - tick counter, clog2(OVERSAMPLE) bits, counts `baudtick` pulses within a bit.
  - bit counter, 3 bits, counts data bits and then stop bits.
  - Both counters clear on every state change.
- Handshake: `tx_ready` = (state==IDLE) && !`baud_pending`. A transfer occurs when `tx_valid` && `tx_ready`. The transfer loads the shift register and moves to START on the next edge.
- Bit advance: a bit ends on the OVERSAMPLE-th `baudtick` counted in the current bit, i.e. when tick counter == OVERSAMPLE-1 and `baudtick` is high.
- START: `txd`=0 → DATA.
- DATA: `txd` = shift[0]. Shift right at the end of each bit. After DATA_BITS bits → PARITY if compiled in, otherwise → STOP.
- PARITY: `txd` = XOR of the data bits, XOR `parity_odd`. → STOP.
- STOP: `txd`=1 for STOP_BITS bits.
  - If `baud_pending` is set at the end of STOP: apply the change → SETTLE.
  - Otherwise → IDLE.
- Baud change:
  - `baud_wr` in IDLE with no transfer in the same cycle: `set_baud` updates on the next edge → SETTLE.
  - `baud_wr` in any other state, or in the same cycle as a transfer: latch `baud_sel` and set `baud_pending`.
  - A later `baud_wr` overwrites the latched value (last write wins).
  - Applying a change clears `baud_pending`.
- SETTLE: wait for 2 `baudtick` pulses, which flushes the generator count under the new rate → IDLE. `tx_ready` is 0 and `txd` is 1 throughout.

## Timing
- Reset values: `txd`=1, `tx_ready`=1, `tx_busy`=0, `baud_pending`=0, `set_baud`=DEFAULT_BAUD, state IDLE, counters 0.
- `txd` falls on the edge after the transfer, so latency is 1 cycle.
- Start-bit length: OVERSAMPLE-1 to OVERSAMPLE tick periods, because tick phase is unaligned. Every later bit is exactly OVERSAMPLE tick periods.
- Frame length in bits: 1 + DATA_BITS + P + STOP_BITS, where P is 1 with parity compiled in and 0 without.
- `tx_ready` rises on the edge that enters IDLE. Back-to-back frames therefore leave at least 1 clock of idle-high `txd` between them.
- `resetn` low mid-frame: all outputs return to reset values immediately. The partial frame is dropped and any pending baud change is discarded.
- A `baudtick` arriving in IDLE is ignored.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- Defined: the PARITY state and the `parity_odd` port exist, and the frame carries 1 parity bit.
- Undefined: the PARITY state and the port are absent, and DATA goes directly to STOP.

## Test plan
- Basic frame at defaults: `tx_data`=8'hA5, baudtick every 4 clocks → `txd` sequence 0,1,0,1,0,0,1,0,1,1. Each bit after the start bit lasts 64 clocks. `tx_ready` returns high after 10 bit times.
- Parity with `UART_TX_PARITY_EN`: 8'h03 with `parity_odd`=0 → parity bit 0; with `parity_odd`=1 → parity bit 1.
- Baud change mid-frame: `baud_wr` with `baud_sel`=11 during DATA → `baud_pending`=1 and `set_baud` stays 8. At the end of STOP, `set_baud`=11. `tx_ready` stays 0 for 2 further baudticks.
- Idle baud change with clamp: `baud_wr` with `baud_sel`=15 in IDLE → `set_baud`=13 next cycle and `baud_pending` stays 0.
- Reset mid-frame: `resetn` low during DATA bit 3 → `txd`=1, `tx_busy`=0, `set_baud`=8 in the same cycle. After release, a fresh 8'h5A frame is transmitted correctly.
- Backpressure: `tx_valid` held high with data 8'h01 then 8'h02 → exactly two frames, with no duplicate and no drop. Each transfer occurs only in a cycle where `tx_ready` is 1.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART transmit controller with between-frame baud selection
//
// Purpose: serialises each accepted word as start, data (LSB first), optional
// parity and stop bits, paced by the 16x oversampling baudtick. It also owns the
// baud generator's rate index (set_baud) so a rate change never lands inside a frame.
// Build option: define UART_TX_PARITY_EN to add the parity bit and the parity_odd port.
//
// Ports:
//   clk, resetn            system clock, asynchronous active-low reset
//   baudtick               one-cycle oversample tick from the baud generator
//   tx_data/tx_valid       word to send and its valid flag
//   tx_ready               word is accepted in a cycle with tx_valid && tx_ready
//   baud_wr/baud_sel       rate change request and index (clamped to 0..13)
//   set_baud               rate index driven to the baud generator
//   baud_pending           a rate change is latched and waits for the frame end
//   parity_odd             1 = odd parity, 0 = even (UART_TX_PARITY_EN only)
//   txd                    serial output, idle high
//   tx_busy                a frame is on the wire

module uart_tx_ctrl #(
    parameter int         DATA_BITS    = 8,
    parameter int         OVERSAMPLE   = 16,
    parameter int         STOP_BITS    = 1,
    parameter logic [3:0] DEFAULT_BAUD = 4'd8
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 baudtick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic                 baud_wr,
    input  logic [3:0]           baud_sel,
    output logic [3:0]           set_baud,
    output logic                 baud_pending,
`ifdef UART_TX_PARITY_EN
    input  logic                 parity_odd,
`endif
    output logic                 txd,
    output logic                 tx_busy
);

    localparam int                TICK_W    = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [2:0]        DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic [3:0]        BAUD_MAX  = 4'd13;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4,
        S_SETTLE = 3'd5
    } state_t;

    function automatic logic [3:0] clamp_baud(input logic [3:0] sel);
        return (sel > BAUD_MAX) ? BAUD_MAX : sel;
    endfunction

    state_t               state_q, state_d;
    logic [TICK_W-1:0]    tick_q, tick_d;
    logic [2:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [3:0]           set_baud_q, set_baud_d;
    logic                 pend_q, pend_d;
    logic [3:0]           pend_sel_q, pend_sel_d;
    logic                 txd_q, txd_d;
    logic                 tx_ready_q, tx_ready_d;
    logic                 tx_busy_q, tx_busy_d;
`ifdef UART_TX_PARITY_EN
    logic                 par_q, par_d;
`endif

    logic                 xfer;
    logic                 bit_end;
    logic                 apply_now;
    logic [3:0]           wr_sel;
    logic [3:0]           apply_sel;

    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        set_baud_d = set_baud_q;
        pend_d     = pend_q;
        pend_sel_d = pend_sel_q;
`ifdef UART_TX_PARITY_EN
        par_d      = par_q;
`endif

        // tx_ready_q always equals (state == IDLE && !pending), so it doubles as
        // the acceptance term without re-decoding the state.
        xfer      = tx_valid && tx_ready_q;
        bit_end   = baudtick && (tick_q == TICK_LAST);
        wr_sel    = clamp_baud(baud_sel);
        // A write arriving in the same cycle a change is applied wins over the
        // older latched value.
        apply_now = pend_q || baud_wr;
        apply_sel = baud_wr ? wr_sel : pend_sel_q;

        // Only an idle controller with no competing transfer may retune at once;
        // any other write is parked until the frame has left the pin.
        if (baud_wr && !(state_q == S_IDLE && !xfer)) begin
            pend_d     = 1'b1;
            pend_sel_d = wr_sel;
        end

        // Ticks seen while idle carry no phase information and are ignored.
        if (state_q != S_IDLE && baudtick) begin
            tick_d = tick_q + TICK_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    shift_d = tx_data;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^tx_data;
`endif
                    state_d = S_START;
                end else if (apply_now) begin
                    set_baud_d = apply_sel;
                    pend_d     = 1'b0;
                    state_d    = S_SETTLE;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d  = bit_q + 3'd1;
                        tick_d = '0;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    if (bit_q == STOP_LAST) begin
                        if (apply_now) begin
                            set_baud_d = apply_sel;
                            pend_d     = 1'b0;
                            state_d    = S_SETTLE;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        bit_d  = bit_q + 3'd1;
                        tick_d = '0;
                    end
                end
            end
            S_SETTLE: begin
                // Two ticks under the new rate flush the generator's old count.
                if (baudtick && tick_q == TICK_W'(1)) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d != state_q) begin
            tick_d = '0;
            bit_d  = '0;
        end

        // Outputs are computed from the next state so they are registered yet
        // change on the same edge as the state.
        tx_ready_d = (state_d == S_IDLE) && !pend_d;
        tx_busy_d  = !(state_d == S_IDLE || state_d == S_SETTLE);

        case (state_d)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: txd_d = par_d ^ parity_odd;
`endif
            default:  txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            tick_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            set_baud_q <= DEFAULT_BAUD;
            pend_q     <= 1'b0;
            pend_sel_q <= DEFAULT_BAUD;
            txd_q      <= 1'b1;
            tx_ready_q <= 1'b1;
            tx_busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            set_baud_q <= set_baud_d;
            pend_q     <= pend_d;
            pend_sel_q <= pend_sel_d;
            txd_q      <= txd_d;
            tx_ready_q <= tx_ready_d;
            tx_busy_q  <= tx_busy_d;
`ifdef UART_TX_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    assign tx_ready     = tx_ready_q;
    assign tx_busy      = tx_busy_q;
    assign txd          = txd_q;
    assign set_baud     = set_baud_q;
    assign baud_pending = pend_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb/tb_uart_tx_ctrl.sv - self-checking bench for uart_tx_ctrl
`timescale 1ns/1ps
module tb_uart_tx_ctrl;

    localparam int OS = 16;
    localparam int DB = 8;
    localparam int SB = 1;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int NBITS = 1 + DB + PB + SB;

    logic       clk      = 1'b0;
    logic       resetn   = 1'b0;
    logic       baudtick = 1'b0;
    logic       tx_valid = 1'b0;
    logic       baud_wr  = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic [3:0] baud_sel = 4'h0;
    logic       tx_ready;
    logic       baud_pending;
    logic       txd;
    logic       tx_busy;
    logic [3:0] set_baud;
`ifdef UART_TX_PARITY_EN
    logic       parity_odd = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    // reference model of the rate selection
    int model_baud = 8;
    bit model_pend = 0;
    int model_sel  = 8;

    int tick_period = 4;
    int phase       = 0;
    bit edge_tick   = 0;
    bit last_xfer   = 0;
    int xfer_count  = 0;

    uart_tx_ctrl #(
        .DATA_BITS   (DB),
        .OVERSAMPLE  (OS),
        .STOP_BITS   (SB),
        .DEFAULT_BAUD(4'd8)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .baudtick    (baudtick),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .baud_wr     (baud_wr),
        .baud_sel    (baud_sel),
        .set_baud    (set_baud),
        .baud_pending(baud_pending),
`ifdef UART_TX_PARITY_EN
        .parity_odd  (parity_odd),
`endif
        .txd         (txd),
        .tx_busy     (tx_busy)
    );

    always #5 clk = ~clk;

    function automatic int clamp(input int s);
        return (s > 13) ? 13 : s;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: samples what the DUT saw at the edge, then drives the next tick.
    task automatic step();
        logic rdy_b, val_b, busy_b;
        rdy_b = tx_ready;
        val_b = tx_valid;
        busy_b = tx_busy;
        @(posedge clk);
        edge_tick = baudtick;
        #1;
        last_xfer = rdy_b && val_b && resetn;
        if (last_xfer) xfer_count++;
        if (busy_b === 1'b0 && tx_busy === 1'b1)
            check("start_only_on_handshake", rdy_b && val_b, 1);
        phase = phase + 1;
        if (phase >= tick_period) phase = 0;
        baudtick = (phase == 0);
    endtask

    task automatic set_period(input int p);
        tick_period = p;
        phase = 0;
    endtask

    task automatic idle_wait(input int n);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (txd !== 1'b1 || tx_busy !== 1'b0) ok = 1'b0;
            step();
        end
        check("idle_quiet", ok, 1);
    endtask

    task automatic settle();
        int n, guard;
        logic ok;
        n = 0; guard = 0; ok = 1'b1;
        while (n < 2 && guard < 20 * tick_period + 20) begin
            if (tx_ready !== 1'b0 || txd !== 1'b1 || tx_busy !== 1'b0) ok = 1'b0;
            step();
            guard++;
            if (edge_tick) n++;
        end
        check("settle_hold", ok, 1);
        check("settle_ready", tx_ready, 1);
    endtask

    task automatic send_frame(input logic [7:0] d, input int wr_tick, input logic [3:0] wr_sel,
                              input logic nxt_valid, input logic [7:0] nxt_data);
        logic exp_bits[$];
        int   ticks, bit_idx, cur_len, guard, bad_cnt;
        logic bad_val, wr_done, pend_chk, busy_ok;
        exp_bits.push_back(1'b0);
        for (int i = 0; i < DB; i++) exp_bits.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
        exp_bits.push_back(1'(($countones(d) + int'(parity_odd)) % 2));
`endif
        for (int i = 0; i < SB; i++) exp_bits.push_back(1'b1);

        tx_data = d;
        tx_valid = 1'b1;
        guard = 0;
        do begin
            step();
            guard++;
        end while (!last_xfer && guard < 400);
        check("xfer_seen", last_xfer, 1);
        tx_valid = nxt_valid;
        tx_data = nxt_data;

        ticks = 0; bit_idx = 0; cur_len = 0; guard = 0; bad_cnt = 0;
        bad_val = 1'b0; wr_done = 1'b0; pend_chk = 1'b0; busy_ok = 1'b1;
        while (bit_idx < NBITS && guard < 2 * OS * NBITS * tick_period + 50) begin
            if (txd !== exp_bits[bit_idx]) begin
                bad_cnt++;
                bad_val = txd;
            end
            if (tx_busy !== 1'b1) busy_ok = 1'b0;
            if (pend_chk) begin
                check("pend_set", baud_pending, 1);
                check("baud_hold", set_baud, model_baud);
                pend_chk = 1'b0;
            end
            if (wr_tick >= 0 && !wr_done && ticks >= wr_tick) begin
                baud_wr = 1'b1;
                baud_sel = wr_sel;
                wr_done = 1'b1;
                pend_chk = 1'b1;
                model_pend = 1;
                model_sel = clamp(int'(wr_sel));
            end
            step();
            baud_wr = 1'b0;
            guard++;
            cur_len++;
            if (edge_tick) ticks++;
            if (ticks == OS * (bit_idx + 1)) begin
                check($sformatf("bit%0d", bit_idx),
                      (bad_cnt == 0) ? exp_bits[bit_idx] : bad_val, exp_bits[bit_idx]);
                if (bit_idx == 0)
                    check("start_len", (cur_len > (OS - 1) * tick_period) && (cur_len <= OS * tick_period), 1);
                else
                    check($sformatf("bit%0d_len", bit_idx), cur_len, OS * tick_period);
                bit_idx++;
                cur_len = 0;
                bad_cnt = 0;
            end
        end
        check("frame_done", bit_idx, NBITS);
        check("busy_in_frame", busy_ok, 1);
        check("txd_after", txd, 1);
        check("busy_after", tx_busy, 0);
        if (model_pend) begin
            check("baud_applied", set_baud, model_sel);
            check("pend_clear", baud_pending, 0);
            check("ready_in_settle", tx_ready, 0);
            model_baud = model_sel;
            model_pend = 0;
            settle();
        end else begin
            check("ready_after", tx_ready, 1);
            check("baud_kept", set_baud, model_baud);
        end
    endtask

    initial begin
        int   guard, ticks, xc0, wt, sel;
        logic [7:0] d;

        resetn = 1'b0;
        repeat (3) step();
        resetn = 1'b1;
        step();

        // reset state
        check("rst_txd", txd, 1);
        check("rst_ready", tx_ready, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_pend", baud_pending, 0);
        check("rst_baud", set_baud, 8);

        // basic frame at defaults, baudtick every 4 clocks
        set_period(4);
        send_frame(8'hA5, -1, 4'd0, 1'b0, 8'h00);
        idle_wait(13);

`ifdef UART_TX_PARITY_EN
        parity_odd = 1'b0;
        send_frame(8'h03, -1, 4'd0, 1'b0, 8'h00);
        parity_odd = 1'b1;
        send_frame(8'h03, -1, 4'd0, 1'b0, 8'h00);
        parity_odd = 1'b0;
        idle_wait(5);
`endif

        // baud change during DATA
        send_frame(8'h3C, OS * 3 + 3, 4'd11, 1'b0, 8'h00);
        idle_wait(7);

        // idle baud change with clamp
        baud_wr = 1'b1;
        baud_sel = 4'd15;
        step();
        baud_wr = 1'b0;
        check("idle_baud_clamp", set_baud, 13);
        check("idle_baud_nopend", baud_pending, 0);
        check("idle_baud_ready", tx_ready, 0);
        model_baud = 13;
        settle();
        send_frame(8'h96, -1, 4'd0, 1'b0, 8'h00);

        // reset during DATA bit 3, with a pending change to discard
        tx_data = 8'hC3;
        tx_valid = 1'b1;
        guard = 0;
        do begin
            step();
            guard++;
        end while (!last_xfer && guard < 400);
        check("rst_xfer_seen", last_xfer, 1);
        tx_valid = 1'b0;
        ticks = 0;
        guard = 0;
        while (ticks < OS * 4 + 5 && guard < 2000) begin
            if (ticks == OS * 2 && baud_wr == 1'b0 && baud_pending !== 1'b1) begin
                baud_wr = 1'b1;
                baud_sel = 4'd2;
            end
            step();
            baud_wr = 1'b0;
            guard++;
            if (edge_tick) ticks++;
        end
        check("pre_rst_pend", baud_pending, 1);
        resetn = 1'b0;
        #1;
        check("mid_rst_txd", txd, 1);
        check("mid_rst_busy", tx_busy, 0);
        check("mid_rst_baud", set_baud, 8);
        check("mid_rst_pend", baud_pending, 0);
        check("mid_rst_ready", tx_ready, 1);
        model_baud = 8;
        model_pend = 0;
        step();
        step();
        resetn = 1'b1;
        step();
        idle_wait(10);
        send_frame(8'h5A, -1, 4'd0, 1'b0, 8'h00);

        // backpressure: tx_valid held across two words
        xc0 = xfer_count;
        send_frame(8'h01, -1, 4'd0, 1'b1, 8'h02);
        send_frame(8'h02, -1, 4'd0, 1'b0, 8'h00);
        check("bp_two_xfers", xfer_count - xc0, 2);
        idle_wait(OS * tick_period * 2);

        // randomized frames, tick rates and baud writes
        for (int k = 0; k < 10; k++) begin
            set_period($urandom_range(1, 4));
            d = 8'($urandom);
            sel = $urandom_range(0, 15);
            wt = ($urandom_range(0, 2) == 0) ? $urandom_range(0, OS * NBITS - 1) : -1;
`ifdef UART_TX_PARITY_EN
            parity_odd = 1'($urandom_range(0, 1));
`endif
            send_frame(d, wt, 4'(sel), 1'b0, 8'h00);
            idle_wait($urandom_range(1, 20));
            if ($urandom_range(0, 3) == 0) begin
                sel = $urandom_range(0, 15);
                baud_wr = 1'b1;
                baud_sel = 4'(sel);
                step();
                baud_wr = 1'b0;
                model_baud = clamp(sel);
                check("rand_idle_baud", set_baud, model_baud);
                check("rand_idle_pend", baud_pending, 0);
                settle();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
